// File: rtl/req_ack_responder.sv
// -----------------------------------------------------------------------------
// req_ack_responder
//
// Four-phase req/ack handshake responder. An initiator raises req together
// with a data byte. The request is accepted from IDLE, and ACK_DELAY cycles
// later the block answers with a one-cycle ack pulse carrying
// rsp_data = req_data + 1 (mod 256). The initiator then drops req to finish
// the handshake. If req is withdrawn before the ack, the transaction is
// dropped and a one-cycle abort pulse is raised instead. Completed
// transactions are counted in done_cnt, which wraps at 2^CNT_W.
//
// Every output is a flop. There is no combinational path from any input to
// any output, so downstream checkers can sample the outputs at posedge clk
// without races.
//
// Parameters:
//   ACK_DELAY  cycles from request acceptance to ack assertion (1..15)
//   CNT_W      width of the completed-transaction counter
//
// Ports:
//   clk       in   system clock, all logic on posedge
//   rst       in   synchronous active-high reset, highest priority
//   req       in   request level, held high until ack (four-phase)
//   req_data  in   request payload, sampled only at the accept edge
//   ack       out  one-cycle acknowledge pulse
//   busy      out  high whenever a transaction is in progress (state != IDLE)
//   rsp_data  out  response byte, valid while ack=1, holds otherwise
//   abort     out  one-cycle pulse when req drops before ack
//   done_cnt  out  completed-transaction count
//
// Optional build macro:
//   REQ_ACK_SVA_EN  when defined, compiles embedded concurrent assertions
//                   on the handshake. Ports and behaviour are unchanged.
// -----------------------------------------------------------------------------
module req_ack_responder #(
   parameter int unsigned ACK_DELAY = 3,
   parameter int unsigned CNT_W     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req,
   input  logic [7:0]       req_data,
   output logic             ack,
   output logic             busy,
   output logic [7:0]       rsp_data,
   output logic             abort,
   output logic [CNT_W-1:0] done_cnt
);

   // The WAIT state runs for ACK_DELAY edges: ACK_DELAY-1 decrements, then
   // the edge that sees zero moves to ACK. Four bits cover the legal range.
   localparam logic [3:0] DELAY_LOAD = 4'(ACK_DELAY - 1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT    = 2'd1,
      ST_ACK     = 2'd2,
      ST_RELEASE = 2'd3
   } state_t;

   state_t     state;
   logic [3:0] delay_cnt;
   logic [7:0] captured;

   // Single registered FSM. ack, abort and busy are computed together with
   // the next state, so each of them is a plain flop output.
   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: every register, including the captured payload, is cleared
         // on reset so a reset mid-transaction cannot leak stale data into
         // a later response.
         state     <= ST_IDLE;
         delay_cnt <= '0;
         captured  <= '0;
         ack       <= 1'b0;
         busy      <= 1'b0;
         abort     <= 1'b0;
         rsp_data  <= '0;
         done_cnt  <= '0;
      end else begin
         // NOTE: state is updated with non-blocking assignments only, so
         // every branch below reads the values from before this edge.
         // ack and abort are pulses; they default low and only the entering
         // transition raises them for a single cycle.
         ack   <= 1'b0;
         abort <= 1'b0;

         unique case (state)
            ST_IDLE: begin
               if (req) begin
                  captured  <= req_data;
                  delay_cnt <= DELAY_LOAD;
                  busy      <= 1'b1;
                  state     <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               // Withdrawal takes priority over the delay expiring: a req
               // seen low on the edge that would have acked is still an abort.
               if (!req) begin
                  abort <= 1'b1;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (delay_cnt == 4'd0) begin
                  ack      <= 1'b1;
                  rsp_data <= captured + 8'd1;
                  state    <= ST_ACK;
               end else begin
                  delay_cnt <= delay_cnt - 4'd1;
               end
            end

            ST_ACK: begin
               // The transaction is complete once ack has been presented,
               // whether or not req is still high at this edge.
               done_cnt <= done_cnt + CNT_W'(1);
               if (req) begin
                  state <= ST_RELEASE;
               end else begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            ST_RELEASE: begin
               // Wait for the initiator to close the four-phase cycle. The
               // low req must pass through IDLE before a new accept.
               if (!req) begin
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end
            end

            default: begin
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef REQ_ACK_SVA_EN
   // Embedded handshake checks. Sampled values at posedge clk: a flop set at
   // edge e is first seen by a property at edge e+1.

   a_ack_single_cycle: assert property (
      @(posedge clk) disable iff (rst) ack |=> !ack
   ) else $error("ack held for more than one cycle");

   a_ack_implies_busy: assert property (
      @(posedge clk) disable iff (rst) ack |-> busy
   ) else $error("ack asserted while not busy");

   a_ack_abort_exclusive: assert property (
      @(posedge clk) disable iff (rst) !(ack && abort)
   ) else $error("ack and abort high together");

   // Accept at edge t: ack set at edge t+ACK_DELAY is seen ACK_DELAY+1
   // sample points later. An abort can be set at edges t+1 .. t+ACK_DELAY.
   a_accept_outcome: assert property (
      @(posedge clk) disable iff (rst)
      (state == ST_IDLE && req) |->
         (##(ACK_DELAY + 1) ack) or (##[2:ACK_DELAY + 1] abort)
   ) else $error("accepted request got neither a timely ack nor an abort");

   // The clear from a reset edge is excluded; only functional updates count.
   a_cnt_after_ack: assert property (
      @(posedge clk) disable iff (rst)
      (!$past(rst) && !$stable(done_cnt)) |-> $past(ack)
   ) else $error("done_cnt changed outside the cycle after ack");
`else
   // Assertions not compiled in this build.
`endif

endmodule

// File: tb/tb_req_ack_responder.sv
// -----------------------------------------------------------------------------
// tb_req_ack_responder
//
// Two instances of req_ack_responder share clk and rst:
//   dut   ACK_DELAY=3, CNT_W=8  cycle-by-cycle vector table plus hold sequence
//   dut1  ACK_DELAY=1, CNT_W=2  minimum latency, back-to-back, counter wrap
// Expected response bytes are queued when a request is driven and popped
// whenever the matching instance shows ack.
// -----------------------------------------------------------------------------
module tb_req_ack_responder;

   localparam int D0  = 3;
   localparam int D1  = 1;
   localparam int CW1 = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       req;
   logic [7:0] req_data;
   logic       ack;
   logic       busy;
   logic [7:0] rsp_data;
   logic       abort;
   logic [7:0] done_cnt;

   logic           req1;
   logic [7:0]     data1;
   logic           ack1;
   logic           busy1;
   logic [7:0]     rsp1;
   logic           abort1;
   logic [CW1-1:0] done1;

   int total = 0;
   int bad   = 0;

   logic [7:0] q0[$];
   logic [7:0] q1[$];

   typedef struct {
      logic       rst;
      logic       req;
      logic [7:0] data;
      logic       push;
      int         ack;
      int         busy;
      int         abort;
      int         rsp;
      int         cnt;
   } vec_t;

   vec_t vecs[$];

   req_ack_responder #(.ACK_DELAY(D0), .CNT_W(8)) dut (
      .clk      (clk),
      .rst      (rst),
      .req      (req),
      .req_data (req_data),
      .ack      (ack),
      .busy     (busy),
      .rsp_data (rsp_data),
      .abort    (abort),
      .done_cnt (done_cnt)
   );

   req_ack_responder #(.ACK_DELAY(D1), .CNT_W(CW1)) dut1 (
      .clk      (clk),
      .rst      (rst),
      .req      (req1),
      .req_data (data1),
      .ack      (ack1),
      .busy     (busy1),
      .rsp_data (rsp1),
      .abort    (abort1),
      .done_cnt (done1)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic add(input int r, input int rq, input int d, input int p,
                      input int a, input int b, input int ab, input int rs, input int cn);
      vec_t v;
      v.rst   = (r != 0);
      v.req   = (rq != 0);
      v.data  = 8'(d);
      v.push  = (p != 0);
      v.ack   = a;
      v.busy  = b;
      v.abort = ab;
      v.rsp   = rs;
      v.cnt   = cn;
      vecs.push_back(v);
   endtask

   // One clock edge, then sample 1 time unit later. Every ack pops the
   // scoreboard of its instance.
   task automatic step();
      @(posedge clk);
      #1;
      check("ack_abort_excl", 32'(ack & abort), 0);
      check("ack_abort_excl1", 32'(ack1 & abort1), 0);
      if (ack) begin
         check("sb0_pending", 32'(q0.size() != 0), 1);
         if (q0.size() != 0) check("sb0_rsp", 32'(rsp_data), 32'(q0.pop_front()));
      end
      if (ack1) begin
         check("sb1_pending", 32'(q1.size() != 0), 1);
         if (q1.size() != 0) check("sb1_rsp", 32'(rsp1), 32'(q1.pop_front()));
      end
   endtask

   // Drive a request on dut from IDLE and return how many edges until ack is
   // visible (the accept edge counts as 1). Returns 0 when ack never comes.
   task automatic run_txn0(input logic [7:0] d, output int lat);
      req      = 1'b1;
      req_data = d;
      q0.push_back(d + 8'd1);
      lat = 0;
      for (int n = 1; n <= 12; n++) begin
         step();
         if (ack) begin
            lat = n;
            break;
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int seq1[5];
      seq1 = '{1, 2, 3, 0, 1};

      rst = 1'b1; req = 1'b0; req_data = 8'h00; req1 = 1'b0; data1 = 8'h00;

      //   rst req data push | ack busy abort rsp  cnt
      // reset with req high, then accepted on the first free edge
      add(1, 1, 'h55, 0,     0, 0, 0, 'h00, 0);
      add(1, 1, 'h55, 0,     0, 0, 0, 'h00, 0);
      add(0, 1, 'h55, 1,     0, 1, 0, 'h00, 0);
      add(0, 1, 'h55, 0,     0, 1, 0, 'h00, 0);
      add(0, 1, 'h55, 0,     0, 1, 0, 'h00, 0);
      add(0, 1, 'h55, 0,     1, 1, 0, 'h56, 0);
      // req drops during ACK: completes and counts, straight to IDLE
      add(0, 0, 'h00, 0,     0, 0, 0, 'h56, 1);
      add(0, 0, 'h00, 0,     0, 0, 0, 'h56, 1);
      // nominal 0x41, payload changes after accept and must be ignored
      add(0, 1, 'h41, 1,     0, 1, 0, 'h56, 1);
      add(0, 1, 'h00, 0,     0, 1, 0, 'h56, 1);
      add(0, 1, 'h00, 0,     0, 1, 0, 'h56, 1);
      add(0, 1, 'h00, 0,     1, 1, 0, 'h42, 1);
      add(0, 1, 'h00, 0,     0, 1, 0, 'h42, 2);
      add(0, 0, 'h00, 0,     0, 0, 0, 'h42, 2);
      // abort at t+2
      add(0, 1, 'h77, 0,     0, 1, 0, 'h42, 2);
      add(0, 1, 'h77, 0,     0, 1, 0, 'h42, 2);
      add(0, 0, 'h77, 0,     0, 0, 1, 'h42, 2);
      add(0, 0, 'h00, 0,     0, 0, 0, 'h42, 2);
      // abort on the very edge the delay would have expired
      add(0, 1, 'h10, 0,     0, 1, 0, 'h42, 2);
      add(0, 1, 'h10, 0,     0, 1, 0, 'h42, 2);
      add(0, 1, 'h10, 0,     0, 1, 0, 'h42, 2);
      add(0, 0, 'h10, 0,     0, 0, 1, 'h42, 2);
      add(0, 0, 'h00, 0,     0, 0, 0, 'h42, 2);
      // reset one edge after accept
      add(0, 1, 'h20, 0,     0, 1, 0, 'h42, 2);
      add(1, 1, 'h20, 0,     0, 0, 0, 'h00, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         rst      = vecs[i].rst;
         req      = vecs[i].req;
         req_data = vecs[i].data;
         if (vecs[i].push) q0.push_back(vecs[i].data + 8'd1);
         step();
         check($sformatf("vec%0d_ack", i),   32'(ack),      vecs[i].ack);
         check($sformatf("vec%0d_busy", i),  32'(busy),     vecs[i].busy);
         check($sformatf("vec%0d_abort", i), 32'(abort),    vecs[i].abort);
         check($sformatf("vec%0d_rsp", i),   32'(rsp_data), vecs[i].rsp);
         check($sformatf("vec%0d_cnt", i),   32'(done_cnt), vecs[i].cnt);
      end

      // After the mid-WAIT reset: no late ack or abort with req low.
      rst = 1'b0;
      req = 1'b0;
      for (int i = 0; i < 10; i++) begin
         step();
         check("post_rst_ack",   32'(ack),   0);
         check("post_rst_abort", 32'(abort), 0);
         check("post_rst_busy",  32'(busy),  0);
      end
      check("post_rst_cnt", 32'(done_cnt), 0);

      // Hold req long past the ack: RELEASE, no second ack. 0xFF wraps to 0x00.
      run_txn0(8'hFF, lat);
      check("hold_latency", lat, D0 + 1);
      check("hold_rsp_wrap", 32'(rsp_data), 'h00);
      for (int i = 0; i < 10; i++) begin
         step();
         check("hold_no_ack", 32'(ack),  0);
         check("hold_busy",   32'(busy), 1);
      end
      check("hold_cnt", 32'(done_cnt), 1);
      req = 1'b0;
      step();
      check("release_busy", 32'(busy), 0);
      run_txn0(8'h30, lat);
      check("rearm_latency", lat, D0 + 1);
      req = 1'b0;
      step();
      check("rearm_cnt",  32'(done_cnt), 2);
      check("rearm_busy", 32'(busy), 0);

      // dut1: ACK_DELAY=1, back-to-back at the minimum period, 2-bit wrap.
      for (int i = 0; i < 5; i++) begin
         req1  = 1'b1;
         data1 = 8'(i * 60 + 15);
         q1.push_back(data1 + 8'd1);
         lat = 0;
         for (int n = 1; n <= 12; n++) begin
            step();
            if (ack1) begin
               lat = n;
               break;
            end
         end
         check($sformatf("wrap%0d_latency", i), lat, D1 + 1);
         req1 = 1'b0;
         step();
         check($sformatf("wrap%0d_cnt", i), 32'(done1), seq1[i]);
         check($sformatf("wrap%0d_busy", i), 32'(busy1), 0);
      end

      check("sb0_drained", q0.size(), 0);
      check("sb1_drained", q1.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
